// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache miss fills onto one memory port, streams 8 word reads per block, steers returns.
// Latency: miss seen in IDLE -> first read next cycle; done pulses with the 8th returned word.
// Backpressure: none on memory; pipe_stall holds the pipeline while any miss is pending or a fill is busy.
module cache_fill_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_addr,
  input  logic        d_miss,
  input  logic [15:0] d_addr,
  output logic        mem_enable,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_in,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_done,
  output logic        d_done,
  output logic        busy,
  output logic        pipe_stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] blk_addr_q;
  // Counters run 0..8: bit 3 acts as the "all eight done" flag.
  logic [3:0]  issue_cnt_q;
  logic [3:0]  recv_cnt_q;
  logic        load_blk;
  logic        sel_d;
  logic        fill_we;

  // Address bits below the block offset never reach the memory port.
  logic unused_bits;
  assign unused_bits = ^{i_addr[3:0], d_addr[3:0], recv_cnt_q[3]};

  assign fill_data  = mem_data_in;
  assign fill_word  = recv_cnt_q[2:0];
  assign busy       = (state_q != IDLE);
  assign pipe_stall = i_miss | d_miss | busy;

  // State register, block address latch and issue/receive counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_addr_q  <= 12'd0;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      if (load_blk) begin
        blk_addr_q  <= sel_d ? d_addr[15:4] : i_addr[15:4];
        issue_cnt_q <= 4'd0;
        recv_cnt_q  <= 4'd0;
      end else begin
        if (mem_enable) issue_cnt_q <= issue_cnt_q + 4'd1;
        if (fill_we)    recv_cnt_q  <= recv_cnt_q + 4'd1;
      end
    end
  end

  // Grant selection (D first, non-preemptive), read issue and fill steering.
  always_comb begin
    state_d    = state_q;
    load_blk   = 1'b0;
    sel_d      = 1'b0;
    mem_enable = 1'b0;
    mem_addr   = 16'd0;
    fill_we    = 1'b0;
    i_fill_we  = 1'b0;
    d_fill_we  = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_miss) begin
          state_d  = FILL_D;
          load_blk = 1'b1;
          sel_d    = 1'b1;
        end else if (i_miss) begin
          state_d  = FILL_I;
          load_blk = 1'b1;
        end
      end
      FILL_I, FILL_D: begin
        if (!issue_cnt_q[3]) begin
          mem_enable = 1'b1;
          mem_addr   = {blk_addr_q, issue_cnt_q[2:0], 1'b0};
        end
        if (mem_data_valid) begin
          fill_we = 1'b1;
          if (state_q == FILL_D) d_fill_we = 1'b1;
          else                   i_fill_we = 1'b1;
          if (recv_cnt_q[2:0] == 3'd7) begin
            state_d = IDLE;
            if (state_q == FILL_D) d_done = 1'b1;
            else                   i_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Shares the single off-chip memory port between the instruction-cache and data-cache miss paths of the pipelined 16-bit processor. On a miss it grants one cache, streams eight sequential word reads for the 16-byte block, counts returning words and steers them into the granted cache's fill port. It also produces the global pipeline stall that holds the F/D and later pipeline registers (their write enable) while any miss is outstanding.

## Interface
- Parameters: none. Block geometry is fixed: 16-byte block, 8 × 16-bit words, 16-bit byte address.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_miss  in  1  I-cache miss request; level, held until i_done.
- i_addr  in  16  I-cache miss byte address.
- d_miss  in  1  D-cache miss request; level, held until d_done.
- d_addr  in  16  D-cache miss byte address.
- mem_enable  out  1  memory read request this cycle.
- mem_addr  out  16  memory read byte address.
- mem_data_valid  in  1  memory returns one word this cycle (in request order).
- mem_data_in  in  16  returned word.
- fill_data  out  16  word to write into the granted cache (= mem_data_in).
- fill_word  out  3  word offset within block of fill_data.
- i_fill_we  out  1  write fill_data into I-cache data array.
- d_fill_we  out  1  write fill_data into D-cache data array.
- i_done  out  1  one-cycle pulse with the 8th I fill write; cache writes tag/valid.
- d_done  out  1  same for D.
- busy  out  1  a fill is in progress (registered).
- pipe_stall  out  1  i_miss | d_miss | busy; drives pipeline-register wen low.

## Operation
- States: IDLE, FILL_I, FILL_D.
- IDLE: if d_miss, latch d_addr[15:4] into blk_addr, go FILL_D; else if i_miss, latch i_addr[15:4], go FILL_I; else stay. D has fixed priority (older instruction).
- Grant is non-preemptive; the other requester waits until IDLE is re-entered.
- Counters (3-bit value + done flag each): issue_cnt 0..8, recv_cnt 0..8; both cleared on entering a FILL state.
- In FILL_x while issue_cnt < 8: mem_enable=1, mem_addr={blk_addr, issue_cnt[2:0], 1'b0}; issue_cnt increments each cycle. Otherwise mem_enable=0, mem_addr=0.
- In FILL_x when mem_data_valid: x_fill_we=1, fill_word=recv_cnt[2:0], recv_cnt increments. If recv_cnt==7: x_done=1, next state IDLE.
- fill_data = mem_data_in combinationally at all times; fill_we gates use.
- mem_data_valid in IDLE: ignored (no we, no count).
- Requester drops miss mid-fill: fill continues to completion (reads in flight); done still pulses.
- Requester must deassert miss by the cycle after done (tag written at that edge); IDLE re-samples then.
- Reset (any state, any cycle): state IDLE, counters 0, blk_addr 0. Outputs at reset: mem_enable 0, mem_addr 0, fill_word 0, i/d_fill_we 0, i/d_done 0, busy 0; pipe_stall = i_miss | d_miss.

## Timing
- Miss seen in IDLE at cycle 0 -> FILL at cycle 1; mem_enable high cycles 1..8 (words 0..7), one per cycle.
- Returned words accepted any cycle in FILL, any spacing; done coincides with 8th valid; IDLE next cycle.
- With 4-cycle memory: valids cycles 5..12, done cycle 12, IDLE cycle 13, second grant earliest cycle 13 -> FILL cycle 14.
- Minimum one IDLE cycle between consecutive fills.
- busy registered; pipe_stall combinational from miss inputs and busy.

## Test plan
- Reset: assert rst mid-cycle with miss low -> all outputs 0 immediately, state IDLE.
- Single I miss i_addr=0x1234, 4-cycle memory -> mem_addr 0x1230,0x1232..0x123E cycles 1..8; i_fill_we with fill_word 0..7 cycles 5..12; i_done only at cycle 12; d_fill_we never.
- i_miss and d_miss rise together (d_addr=0xABCD, i_addr=0x0042) -> D block 0xABC0..0xABCE first, d_done, one IDLE cycle, then I block 0x0040..0x004E; pipe_stall high throughout.
- Irregular memory returns (valids at gaps of 0–3 cycles) -> fill_word increments only on valid, done on exactly the 8th valid.
- Reset after 3 returned words of a D fill -> outputs 0, IDLE; d_miss still high -> new fill restarts at word 0 with mem_addr block base.
- mem_data_valid pulses in IDLE ignored; i_miss dropped after cycle 2 -> fill still completes with i_done.
